// File: rtl/vga_ctrl_pkg.sv
// Shared definitions for the pixel-buffer swap controller.
// Holds the controller state encoding and the pixel DMA control-slave
// register map (word offsets and the STATUS swap-pending bit).
package vga_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_BACK,
        ST_WR_SWAP,
        ST_RD_STAT,
        ST_WAIT_STAT,
        ST_DONE,
        ST_ERR
    } state_t;

    localparam logic [1:0] REG_BUFFER     = 2'd0;
    localparam logic [1:0] REG_BACKBUFFER = 2'd1;
    localparam logic [1:0] REG_STATUS     = 2'd3;

    localparam int STATUS_SWAP_BIT = 0;

endpackage

// File: rtl/pixel_swap_ctrl.sv
// pixel_swap_ctrl: hands a new frame-buffer address to a pixel DMA engine.
// A request is parked in a one-entry hold register, then the FSM writes the
// address to BACKBUFFER, triggers the swap by writing BUFFER, and polls STATUS
// until the swap-pending bit clears (done) or the poll limit expires (error).
//
// Ports:
//   sys_clk_clk, sys_reset     clock, synchronous active-high reset
//   swap_req/swap_addr         swap request and new buffer base address
//   swap_ready                 request can be accepted (hold register empty)
//   swap_done/swap_err         one-cycle completion / timeout pulses
//   busy                       FSM not idle
//   front_addr, swap_count     displayed buffer, completed swap counter
//   ctl_*                      control-slave master port (read latency 1)
module pixel_swap_ctrl
    import vga_ctrl_pkg::*;
#(
    parameter int unsigned  POLL_TIMEOUT = 1000000,
    parameter logic [31:0]  INIT_FRONT   = 32'h0000_0000
) (
    input  logic        sys_clk_clk,
    input  logic        sys_reset,
    input  logic        swap_req,
    input  logic [31:0] swap_addr,
    output logic        swap_ready,
    output logic        swap_done,
    output logic        swap_err,
    output logic        busy,
    output logic [31:0] front_addr,
    output logic [15:0] swap_count,
    output logic [1:0]  ctl_address,
    output logic [3:0]  ctl_byteenable,
    output logic        ctl_read,
    output logic        ctl_write,
    output logic [31:0] ctl_writedata,
    input  logic [31:0] ctl_readdata
);

    state_t      state;
    state_t      next_state;
    logic        hold_valid;
    logic        hold_valid_nxt;
    logic [31:0] hold_addr;
    logic [31:0] work_addr;
    logic        load_work;
    logic        accept;
    logic [31:0] poll_cnt;
    logic        stat_pending;
    logic        poll_expired;

    logic [1:0]  ctl_address_nxt;
    logic        ctl_read_nxt;
    logic        ctl_write_nxt;
    logic [31:0] ctl_writedata_nxt;

    // Only the swap-pending bit of STATUS matters.
    logic        unused_readdata;
    assign unused_readdata = ^{ctl_readdata[31:1]};

    assign stat_pending = ctl_readdata[STATUS_SWAP_BIT];
    assign poll_expired = (poll_cnt >= (POLL_TIMEOUT - 32'd1));
    assign accept       = swap_req && swap_ready;

    always_comb begin
        next_state     = state;
        hold_valid_nxt = hold_valid;
        load_work      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (hold_valid) begin
                    next_state     = ST_WR_BACK;
                    hold_valid_nxt = 1'b0;
                    load_work      = 1'b1;
                end
            end
            ST_WR_BACK:   next_state = ST_WR_SWAP;
            ST_WR_SWAP:   next_state = ST_RD_STAT;
            ST_RD_STAT:   next_state = ST_WAIT_STAT;
            ST_WAIT_STAT: begin
                // Clear status wins; otherwise an expired limit beats a re-poll.
                if (!stat_pending)     next_state = ST_DONE;
                else if (poll_expired) next_state = ST_ERR;
                else                   next_state = ST_RD_STAT;
            end
            ST_DONE:      next_state = ST_IDLE;
            ST_ERR:       next_state = ST_IDLE;
            default:      next_state = ST_IDLE;
        endcase
        // accept needs an empty hold register, load_work a full one: never both.
        if (accept) hold_valid_nxt = 1'b1;
    end

    // Bus strobes are decoded from the next state so the registered outputs
    // line up with the cycle the FSM is in that state.
    always_comb begin
        ctl_address_nxt   = 2'd0;
        ctl_read_nxt      = 1'b0;
        ctl_write_nxt     = 1'b0;
        ctl_writedata_nxt = 32'd0;
        case (next_state)
            ST_WR_BACK: begin
                ctl_write_nxt     = 1'b1;
                ctl_address_nxt   = REG_BACKBUFFER;
                ctl_writedata_nxt = hold_addr;
            end
            ST_WR_SWAP: begin
                ctl_write_nxt     = 1'b1;
                ctl_address_nxt   = REG_BUFFER;
            end
            ST_RD_STAT: begin
                ctl_read_nxt      = 1'b1;
                ctl_address_nxt   = REG_STATUS;
            end
            default: ;
        endcase
    end

    always_ff @(posedge sys_clk_clk) begin
        if (sys_reset) begin
            state          <= ST_IDLE;
            hold_valid     <= 1'b0;
            swap_ready     <= 1'b0;
            swap_done      <= 1'b0;
            swap_err       <= 1'b0;
            busy           <= 1'b0;
            front_addr     <= INIT_FRONT;
            swap_count     <= 16'd0;
            poll_cnt       <= 32'd0;
            ctl_address    <= 2'd0;
            ctl_byteenable <= 4'h0;
            ctl_read       <= 1'b0;
            ctl_write      <= 1'b0;
            ctl_writedata  <= 32'd0;
        end else begin
            state          <= next_state;
            hold_valid     <= hold_valid_nxt;
            swap_ready     <= !hold_valid_nxt;
            swap_done      <= (next_state == ST_DONE);
            swap_err       <= (next_state == ST_ERR);
            busy           <= (next_state != ST_IDLE);
            ctl_address    <= ctl_address_nxt;
            ctl_read       <= ctl_read_nxt;
            ctl_write      <= ctl_write_nxt;
            ctl_writedata  <= ctl_writedata_nxt;
            ctl_byteenable <= (ctl_read_nxt || ctl_write_nxt) ? 4'hF : 4'h0;
            if (next_state == ST_DONE) begin
                front_addr <= work_addr;
                swap_count <= swap_count + 16'd1;
            end
            // Counts completed status polls of the current swap.
            if (state == ST_WR_SWAP)
                poll_cnt <= 32'd0;
            else if (state == ST_WAIT_STAT)
                poll_cnt <= poll_cnt + 32'd1;
        end
    end

    // Address registers carry data only; they are qualified by hold_valid/state.
    always_ff @(posedge sys_clk_clk) begin
        if (accept)    hold_addr <= swap_addr;
        if (load_work) work_addr <= hold_addr;
    end

endmodule

// File: tb/tb_pixel_swap_ctrl.sv
// Directed bench for pixel_swap_ctrl with a latency-1 STATUS responder.
module tb_pixel_swap_ctrl;

    localparam logic [31:0] INIT_F = 32'h1234_0000;

    logic        clk = 1'b0;
    logic        sys_reset = 1'b1;
    logic        swap_req = 1'b0;
    logic [31:0] swap_addr = 32'd0;
    logic        swap_ready, swap_done, swap_err, busy;
    logic [31:0] front_addr;
    logic [15:0] swap_count;
    logic [1:0]  ctl_address;
    logic [3:0]  ctl_byteenable;
    logic        ctl_read, ctl_write;
    logic [31:0] ctl_writedata;
    logic [31:0] ctl_readdata = 32'd0;

    pixel_swap_ctrl #(.POLL_TIMEOUT(16), .INIT_FRONT(INIT_F)) dut (
        .sys_clk_clk(clk), .sys_reset(sys_reset),
        .swap_req(swap_req), .swap_addr(swap_addr), .swap_ready(swap_ready),
        .swap_done(swap_done), .swap_err(swap_err), .busy(busy),
        .front_addr(front_addr), .swap_count(swap_count),
        .ctl_address(ctl_address), .ctl_byteenable(ctl_byteenable),
        .ctl_read(ctl_read), .ctl_write(ctl_write),
        .ctl_writedata(ctl_writedata), .ctl_readdata(ctl_readdata)
    );

    always #5 clk = ~clk;

    int ecnt = 0;
    always @(posedge clk) ecnt <= ecnt + 1;

    // STATUS responder: pending while stuck or until busy_until reads are served.
    bit stuck = 1'b0;
    int busy_until = 0;
    int rsp_reads = 0;
    always @(posedge clk) begin
        if (ctl_read) begin
            ctl_readdata <= (stuck || rsp_reads < busy_until) ? 32'h1 : 32'h0;
            rsp_reads    <= rsp_reads + 1;
        end
    end

    typedef struct { logic [1:0] a; logic [31:0] d; } wr_t;
    wr_t wr_q[$];
    int rd_total = 0, done_total = 0, err_total = 0;
    int last_rd_e = 0, last_done_e = 0, clash = 0, be_bad = 0;

    always @(negedge clk) begin
        if (ctl_read && ctl_write) clash++;
        if ((ctl_read || ctl_write) ? (ctl_byteenable !== 4'hF) : (ctl_byteenable !== 4'h0)) be_bad++;
        if (ctl_read) begin rd_total++; last_rd_e = ecnt; end
        if (ctl_write) wr_q.push_back('{ctl_address, ctl_writedata});
        if (swap_done) begin done_total++; last_done_e = ecnt; end
        if (swap_err) err_total++;
    end

    int n_tests = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge; returns just after the accepting clock edge.
    task automatic submit(input logic [31:0] a);
        swap_req  = 1'b1;
        swap_addr = a;
        @(posedge clk);
        #1;
        swap_req  = 1'b0;
    endtask

    // k = number of negedges until swap_done is seen (0 if never).
    task automatic wait_done(output int k);
        k = 0;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (swap_done) begin k = i; break; end
        end
    endtask

    initial begin
        int k, k1, k2, wb, r0, d0, e0;

        // Reset state
        tick(3);
        chk("rst_ready", swap_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_front", front_addr, INIT_F);
        chk("rst_count", swap_count, 0);
        chk("rst_ctl", {ctl_read, ctl_write, ctl_byteenable, ctl_address}, 0);
        sys_reset = 1'b0;
        tick(1);
        chk("rst_ready_after", swap_ready, 1);

        // Single swap, status clear on first read
        wb = wr_q.size(); r0 = rd_total; busy_until = rsp_reads;
        submit(32'h0800_0000);
        wait_done(k);
        chk("s1_latency", k, 6);
        tick(1);
        chk("s1_done_pulse", swap_done, 0);
        chk("s1_front", front_addr, 32'h0800_0000);
        chk("s1_count", swap_count, 1);
        chk("s1_busy", busy, 0);
        chk("s1_nwrites", wr_q.size() - wb, 2);
        chk("s1_w0_addr", wr_q[wb].a, 1);
        chk("s1_w0_data", wr_q[wb].d, 32'h0800_0000);
        chk("s1_w1_addr", wr_q[wb+1].a, 0);
        chk("s1_w1_data", wr_q[wb+1].d, 0);
        chk("s1_reads", rd_total - r0, 1);

        // Status pending for three reads
        r0 = rd_total; busy_until = rsp_reads + 3;
        submit(32'h0900_0000);
        wait_done(k);
        chk("s2_latency", k, 12);
        tick(1);
        chk("s2_reads", rd_total - r0, 4);
        chk("s2_done_after_read", last_done_e - last_rd_e, 2);
        chk("s2_front", front_addr, 32'h0900_0000);
        chk("s2_count", swap_count, 2);

        // Poll timeout
        stuck = 1'b1; r0 = rd_total; d0 = done_total; e0 = err_total;
        submit(32'h0A00_0000);
        k = 0;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (swap_err) begin k = i; break; end
        end
        chk("s3_err_latency", k, 36);
        tick(1);
        chk("s3_reads", rd_total - r0, 16);
        chk("s3_err_pulse", swap_err, 0);
        chk("s3_front", front_addr, 32'h0900_0000);
        chk("s3_count", swap_count, 2);
        chk("s3_busy", busy, 0);
        tick(5);
        chk("s3_err_once", err_total - e0, 1);
        chk("s3_no_done", done_total - d0, 0);
        stuck = 1'b0;

        // Second request while busy
        busy_until = rsp_reads; d0 = done_total;
        submit(32'h0B00_0000);
        @(negedge clk);
        chk("s4_ready_full", swap_ready, 0);
        @(negedge clk);
        chk("s4_ready_free", swap_ready, 1);
        chk("s4_busy", busy, 1);
        submit(32'h0810_0000);
        @(negedge clk);
        chk("s4_ready_held", swap_ready, 0);
        wait_done(k1);
        chk("s4_k1", k1, 3);
        tick(1);
        chk("s4_front_a", front_addr, 32'h0B00_0000);
        wait_done(k2);
        chk("s4_k2", k2, 5);
        tick(1);
        chk("s4_front_b", front_addr, 32'h0810_0000);
        chk("s4_two_done", done_total - d0, 2);
        chk("s4_count", swap_count, 4);

        // Counter wrap from 16'hFFFF
        force dut.swap_count = 16'hFFFF;
        @(negedge clk);
        release dut.swap_count;
        busy_until = rsp_reads;
        submit(32'h0C00_0000);
        wait_done(k);
        tick(1);
        chk("s5_count_wrap", swap_count, 0);
        chk("s5_front", front_addr, 32'h0C00_0000);

        // Reset in RD_STAT with a held request
        busy_until = rsp_reads + 50;
        submit(32'h0D00_0000);
        @(negedge clk);
        @(negedge clk);
        submit(32'h0E00_0000);
        k = 0;
        for (int i = 1; i <= 50; i++) begin
            @(negedge clk);
            if (ctl_read) begin k = i; break; end
        end
        chk("s6_reached_rd", (k != 0), 1);
        sys_reset = 1'b1;
        @(negedge clk);
        chk("s6_busy", busy, 0);
        chk("s6_ctl", {ctl_read, ctl_write, ctl_byteenable, ctl_address}, 0);
        chk("s6_wdata", ctl_writedata, 0);
        chk("s6_pulses", {swap_done, swap_err}, 0);
        chk("s6_ready", swap_ready, 0);
        chk("s6_front", front_addr, INIT_F);
        chk("s6_count", swap_count, 0);
        sys_reset = 1'b0;
        d0 = done_total; e0 = err_total; r0 = rd_total;
        tick(1);
        chk("s6_ready_after", swap_ready, 1);
        tick(30);
        chk("s6_no_done", done_total - d0, 0);
        chk("s6_no_err", err_total - e0, 0);
        chk("s6_no_reads", rd_total - r0, 0);
        chk("s6_idle", busy, 0);

        // Whole-run bus invariants
        chk("rw_exclusive", clash, 0);
        chk("byteenable", be_bad, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
